// File: rtl/arb_memory.sv
// arb_memory: NUM_PORTS requesters share one byte-addressable storage array
// through a round-robin arbiter. One access is granted per cycle; reads return
// 4 little-endian bytes READ_LATENCY edges after the grant edge.
// Optional feature macro: MEM_BOUNDS_CHECK_EN (sticky oob_err flag + $error).
// Storage is never cleared by reset so preloaded contents survive.

module arb_memory #(
  parameter int SIZE         = 1024,
  parameter int NUM_PORTS    = 2,
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [2*NUM_PORTS-1:0]      size,
  input  logic [ADDR_W*NUM_PORTS-1:0] addr,
  input  logic [32*NUM_PORTS-1:0]     wdata,
  output logic [NUM_PORTS-1:0]        gnt,
  output logic [NUM_PORTS-1:0]        rvalid,
  output logic [32*NUM_PORTS-1:0]     rdata,
  output logic                        oob_err
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int MW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int RL = READ_LATENCY;
  // Byte addresses are formed one bit wider so addr+i wrapping past 2^ADDR_W
  // lands above SIZE and is treated as out of range.
  localparam logic [ADDR_W:0] SIZE_X = (ADDR_W+1)'(SIZE);

  logic [7:0] mem [SIZE];

  logic [PW-1:0]   ptr_q, ptr_d;
  logic            gnt_any;
  logic [PW-1:0]   gnt_idx;

  logic            sel_we;
  logic [1:0]      sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]     sel_wdata;
  logic [2:0]      nbytes;
  logic [ADDR_W:0] ba [4];
  logic [3:0]      in_rng;
  logic [MW-1:0]   mi [4];
  logic [3:0]      wr_be;
  logic [31:0]     rd_word;

  logic [RL-1:0]   pv_q, pv_d;
  logic [PW-1:0]   pp_q [RL];
  logic [PW-1:0]   pp_d [RL];
  logic [31:0]     pd_q [RL];
  logic [31:0]     pd_d [RL];
  logic [31:0]     rhold_q [NUM_PORTS];
  logic [31:0]     rhold_d [NUM_PORTS];

  // Round-robin search from the pointer; the winner's successor becomes the next pointer.
  always_comb begin
    int p;
    p       = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      p = (int'(ptr_q) + i) % NUM_PORTS;
      if (!gnt_any && req[p]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(p);
      end
    end
    if (rst) gnt_any = 1'b0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (gnt_idx == PW'(NUM_PORTS-1)) ? '0 : gnt_idx + 1'b1;
  end

  // Decode the granted port's access: byte addresses, range checks, read word, write enables.
  always_comb begin
    sel_we    = we[gnt_idx];
    sel_size  = size[int'(gnt_idx)*2 +: 2];
    sel_addr  = addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    sel_wdata = wdata[int'(gnt_idx)*32 +: 32];
    case (sel_size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    rd_word = '0;
    wr_be   = '0;
    in_rng  = '0;
    for (int b = 0; b < 4; b++) begin
      ba[b]     = {1'b0, sel_addr} + (ADDR_W+1)'(b);
      in_rng[b] = (ba[b] < SIZE_X);
      mi[b]     = ba[b][MW-1:0];
      rd_word[8*b +: 8] = in_rng[b] ? mem[mi[b]] : 8'h00;
      wr_be[b]  = gnt_any && sel_we && (3'(b) < nbytes) && in_rng[b];
    end
  end

  // Commit write bytes on the grant edge; storage has no reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_be[b]) mem[mi[b]] <= sel_wdata[8*b +: 8];
    end
  end

  // Read response pipeline plus per-port hold of the last returned word.
  always_comb begin
    pv_d = '0;
    for (int s = RL-1; s > 0; s--) begin
      pv_d[s] = pv_q[s-1];
      pp_d[s] = pp_q[s-1];
      pd_d[s] = pd_q[s-1];
    end
    pv_d[0] = gnt_any && !sel_we;
    pp_d[0] = gnt_idx;
    pd_d[0] = rd_word;
    rhold_d = rhold_q;
    if (pv_q[RL-1]) rhold_d[pp_q[RL-1]] = pd_q[RL-1];
  end

  // Drive per-port response channels from the last pipeline stage.
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      rvalid[k] = pv_q[RL-1] && (pp_q[RL-1] == PW'(k));
      rdata[32*k +: 32] = rvalid[k] ? pd_q[RL-1] : rhold_q[k];
    end
  end

  // Arbiter pointer and response state; reset flushes in-flight reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      pv_q  <= '0;
      for (int s = 0; s < RL; s++) begin
        pp_q[s] <= '0;
        pd_q[s] <= '0;
      end
      for (int k = 0; k < NUM_PORTS; k++) rhold_q[k] <= '0;
    end else begin
      ptr_q   <= ptr_d;
      pv_q    <= pv_d;
      pp_q    <= pp_d;
      pd_q    <= pd_d;
      rhold_q <= rhold_d;
    end
  end

`ifdef MEM_BOUNDS_CHECK_EN
  logic oob_q, oob_d, oob_hit;

  // Flag any granted access touching a byte at or beyond SIZE (reads touch all 4 bytes).
  always_comb begin
    oob_hit = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (gnt_any && !in_rng[b] && (!sel_we || (3'(b) < nbytes))) oob_hit = 1'b1;
    end
    oob_d = oob_q | oob_hit;
  end

  // Sticky out-of-bounds flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) oob_q <= 1'b0;
    else     oob_q <= oob_d;
  end

`ifndef SYNTHESIS
  // Simulation report of the offending port and address.
  always @(posedge clk) begin
    if (oob_hit) $error("arb_memory: out-of-bounds access port %0d addr 0x%0h", gnt_idx, sel_addr);
  end
`endif

  assign oob_err = oob_q;
`else
  assign oob_err = 1'b0;
`endif

endmodule
